conv_layer_scheduler: RTL

- Layer-level sequencer for one convolution layer.
- Walks every output channel, output row and output column. For each output pixel it launches one 5x5 window fetch on the window address generator with start plus base addresses, then waits for that generator's done pulse.
- After a fixed drain it issues a result write strobe and address to the output buffer.
- Sits between the top-level layer control and the window address generator / MAC datapath.

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_layer_scheduler_if.sv | 25 ++
 rtl/conv_pos_counter.sv | 45 ++++
 rtl/conv_layer_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the conv layer scheduler: FSM state encoding, address widths, default geometry.
// Pure declarations; no logic.
package conv_pkg;
    localparam int IMG_AW    = 10;
    localparam int W_AW      = 8;
    localparam int RES_W     = 13;
    localparam int DEF_IMG_W = 32;
    localparam int DEF_K     = 5;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Layer control, window-generator and result-write signals of the scheduler.
// master = scheduler side, slave = surrounding control / generator / output buffer.
interface conv_layer_scheduler_if;
    import conv_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              agu_start;
    logic [IMG_AW-1:0] agu_img_base;
    logic [W_AW-1:0]   agu_w_base;
    logic              agu_done;
    logic              res_wr_en;
    logic [RES_W-1:0]  res_addr;

    modport master (
        input  start, agu_done,
        output busy, done, agu_start, agu_img_base, agu_w_base, res_wr_en, res_addr
    );

    modport slave (
        output start, agu_done,
        input  busy, done, agu_start, agu_img_base, agu_w_base, res_wr_en, res_addr
    );
endinterface

// File: rtl/conv_pos_counter.sv
// Nested col/row/ch position counter; one step per output pixel, clr restarts at (0,0,0).
// Wrap and last flags decode the current position combinationally.
module conv_pos_counter #(
    parameter int OUT_SIZE   = 28,
    parameter int NUM_OUT_CH = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    output logic col_wrap,
    output logic row_wrap,
    output logic last
);
    localparam int CW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int CHW = $clog2(NUM_OUT_CH + 1);

    logic [CW-1:0]  col;
    logic [CW-1:0]  row;
    logic [CHW-1:0] ch;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (step) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row <= '0;
                    ch  <= ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign col_wrap = (col == CW'(OUT_SIZE - 1));
    assign row_wrap = (row == CW'(OUT_SIZE - 1));
    assign last     = col_wrap && row_wrap && (ch == CHW'(NUM_OUT_CH - 1));
endmodule

// File: rtl/conv_layer_scheduler.sv
// Walks ch/row/col of one conv layer: one window launch per pixel, result write DRAIN_CYCLES after agu_done.
// No backpressure beyond agu_done pacing; CONV_SCHED_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module conv_layer_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W        = DEF_IMG_W,
    parameter int K            = DEF_K,
    parameter int NUM_OUT_CH   = 6,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
`ifdef CONV_SCHED_PERF_EN
    output logic [31:0] perf_cycles,
`endif
    conv_layer_scheduler_if.master bus
);
    localparam int OUT_SIZE = IMG_W - K + 1;
    localparam int W_STEP   = K * K;
    localparam int DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [2:0]        state;
    logic [DW-1:0]     drain_cnt;
    logic [IMG_AW-1:0] row_base;
    logic              accept;
    logic              step;
    logic              col_wrap;
    logic              row_wrap;
    logic              last;

    assign accept = (state == IDLE) && bus.start;
    assign step   = (state == DRAIN) && (drain_cnt == '0);

    conv_pos_counter #(
        .OUT_SIZE   (OUT_SIZE),
        .NUM_OUT_CH (NUM_OUT_CH)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .step     (step),
        .col_wrap (col_wrap),
        .row_wrap (row_wrap),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            drain_cnt        <= '0;
            row_base         <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.agu_start    <= 1'b0;
            bus.agu_img_base <= '0;
            bus.agu_w_base   <= '0;
            bus.res_wr_en    <= 1'b0;
            bus.res_addr     <= '0;
        end else begin
            bus.agu_start <= 1'b0;
            bus.res_wr_en <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state            <= ISSUE;
                        bus.busy         <= 1'b1;
                        bus.agu_start    <= 1'b1;
                        row_base         <= '0;
                        bus.agu_img_base <= '0;
                        bus.agu_w_base   <= '0;
                        bus.res_addr     <= '0;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.agu_done) begin
                        state         <= DRAIN;
                        drain_cnt     <= DW'(DRAIN_CYCLES - 1);
                        // Strobe is registered, so it is raised on entry to the final drain cycle.
                        bus.res_wr_en <= (DRAIN_CYCLES == 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        bus.res_addr <= bus.res_addr + 1'b1;
                        if (!col_wrap) begin
                            bus.agu_img_base <= bus.agu_img_base + 1'b1;
                        end else if (!row_wrap) begin
                            row_base         <= row_base + IMG_AW'(IMG_W);
                            bus.agu_img_base <= row_base + IMG_AW'(IMG_W);
                        end else begin
                            row_base         <= '0;
                            bus.agu_img_base <= '0;
                            bus.agu_w_base   <= bus.agu_w_base + W_AW'(W_STEP);
                        end
                        if (last) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            bus.agu_start <= 1'b1;
                        end
                    end else begin
                        drain_cnt     <= drain_cnt - 1'b1;
                        bus.res_wr_en <= (drain_cnt == DW'(1));
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            perf_cycles <= '0;
        end else if (bus.busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 1'b1;
        end
    end
`endif
endmodule
